// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit RISC core: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional performance counters (cyc_cnt, ret_cnt) are enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       instr_opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_LDWB   = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_e;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        illegal_d  = illegal_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = instr_opcode;
                if (instr_opcode <= OP_ST) begin
                    state_d = S_ADDR;
                end else if (instr_opcode <= 4'd9) begin
                    state_d = S_EXEC;
                end else if (instr_opcode == OP_BEQ || instr_opcode == OP_BNE) begin
                    state_d = S_BRANCH;
                end else if (instr_opcode == OP_JMP) begin
                    state_d = S_JUMP;
                end else begin
                    // Undefined opcode retires as a NOP but leaves a sticky flag.
                    illegal_d = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDR: begin
                alu_op  = 2'b10;
                alu_src = 1'b1;
                state_d = S_MEM;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_ST);
                if (dmem_ready) begin
                    state_d = (op_q == OP_LD) ? S_LDWB : S_FETCH;
                end
            end
            S_LDWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = 2'b01;
                pc_src   = 2'b01;
                pc_write = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Asynchronously quiet the bus while reset is held so an in-flight access is dropped at once.
        if (!rst_n) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'b00;
            alu_op     = 2'b00;
            alu_src    = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    assign illegal = illegal_q & rst_n;
    assign state   = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q;
    logic [CNT_W-1:0] ret_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            if (state_d == S_FETCH && state_q != S_FETCH) begin
                ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected outputs are queued, then replayed and compared.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] instr_opcode = 4'd0;
    logic       zero = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src, alu_op;
    logic       alu_src, reg_write, mem_to_reg, illegal;
    logic [3:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [3:0] cyc_cnt, ret_cnt;
`endif

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
`ifdef CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  opc;
        logic        z;
        logic        ir;
        logic        dr;
        logic [16:0] exp;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic illegal_m = 1'b0;

    // Expected vector: {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_op, alu_src, reg_write, mem_to_reg, illegal}
    function automatic logic [16:0] mk(input logic [3:0] st, input logic imr, input logic dmr,
                                       input logic we, input logic irw, input logic pcw,
                                       input logic [1:0] ps, input logic [1:0] ao,
                                       input logic as, input logic rw, input logic m2r);
        return {st, imr, dmr, we, irw, pcw, ps, ao, as, rw, m2r, illegal_m};
    endfunction

    function automatic logic [16:0] obs();
        return {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_op,
                alu_src, reg_write, mem_to_reg, illegal};
    endfunction

    task automatic push(input string n, input logic rs, input logic [3:0] o, input logic z,
                        input logic ir, input logic dr, input logic [16:0] e);
        rec_t r;
        r.name = n; r.rst = rs; r.opc = o; r.z = z; r.ir = ir; r.dr = dr; r.exp = e;
        sb.push_back(r);
    endtask

    // Ready inputs are held high outside their request state to show they are ignored there.
    task automatic add_instr(input logic [3:0] o, input logic z, input int iw, input int dw);
        for (int i = 0; i < iw; i++)
            push("fetch_wait", 1, o, z, 0, 1, mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        push("fetch", 1, o, z, 1, 1, mk(0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0));
        push("decode", 1, o, z, 1, 1, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        if (o <= 4'd1) begin
            push("addr", 1, o, z, 1, 1, mk(4, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0));
            for (int i = 0; i < dw; i++)
                push("mem_wait", 1, o, z, 1, 0, mk(5, 0, 1, o[0], 0, 0, 2'b00, 2'b00, 0, 0, 0));
            push("mem", 1, o, z, 1, 1, mk(5, 0, 1, o[0], 0, 0, 2'b00, 2'b00, 0, 0, 0));
            if (o == 4'd0)
                push("ldwb", 1, o, z, 1, 1, mk(6, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1));
        end else if (o <= 4'd9) begin
            push("exec", 1, o, z, 1, 1, mk(2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
            push("aluwb", 1, o, z, 1, 1, mk(3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0));
        end else if (o == 4'd11 || o == 4'd12) begin
            push("branch", 1, o, z, 1, 1,
                 mk(7, 0, 0, 0, 0, (o == 4'd11) ? z : ~z, 2'b01, 2'b01, 0, 0, 0));
        end else if (o == 4'd13) begin
            push("jump", 1, o, z, 1, 1, mk(8, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0));
        end else begin
            illegal_m = 1'b1;
        end
    endtask

    task automatic step(output rec_t r);
        r = sb.pop_front();
        @(negedge clk);
        rst_n = r.rst; instr_opcode = r.opc; zero = r.z;
        imem_ready = r.ir; dmem_ready = r.dr;
        #1;
    endtask

    task automatic test_reset();
        rec_t r;
        for (int i = 0; i < 3; i++)
            push("reset_hold", 0, 4'b0010, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        add_instr(4'b0010, 0, 0, 0);
        push("rtype_done", 1, 4'b0010, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL reset/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_load_store();
        rec_t r;
        add_instr(4'b0000, 0, 1, 2);
        add_instr(4'b0001, 1, 0, 0);
        add_instr(4'b0001, 0, 2, 1);
        add_instr(4'b1001, 0, 0, 0);
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL ldst/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_branch_jump();
        rec_t r;
        add_instr(4'b1011, 1, 0, 0);
        add_instr(4'b1011, 0, 0, 0);
        add_instr(4'b1100, 0, 0, 0);
        add_instr(4'b1100, 1, 0, 0);
        add_instr(4'b1101, 1, 1, 0);
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL branch/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_illegal();
        rec_t r;
        add_instr(4'b1111, 0, 0, 0);
        add_instr(4'b0101, 0, 0, 0);
        add_instr(4'b1010, 0, 0, 0);
        add_instr(4'b1110, 0, 0, 0);
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL illegal/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        rec_t r;
        push("fetch", 1, 4'b0001, 0, 1, 1, mk(0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0));
        push("decode", 1, 4'b0001, 0, 1, 1, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        push("addr", 1, 4'b0001, 0, 1, 1, mk(4, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0));
        push("mem_wait", 1, 4'b0001, 0, 1, 0, mk(5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        illegal_m = 1'b0;
        push("rst_in_mem", 0, 4'b0001, 0, 1, 0, mk(5, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        push("after_rst", 1, 4'b0001, 0, 0, 1, mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL rst_mid/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf_counters();
        rec_t r;
        push("perf_rst", 0, 4'b1101, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            add_instr(4'b1101, 0, 0, 0);
        push("perf_idle", 1, 4'b1101, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL perf/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
        checks++;
        if (ret_cnt !== 4'd5) begin
            errors++;
            $display("FAIL ret_cnt: got %0d want 5", ret_cnt);
        end
        checks++;
        if (cyc_cnt !== 4'd15) begin
            errors++;
            $display("FAIL cyc_cnt: got %0d want 15", cyc_cnt);
        end
        for (int i = 0; i < 2; i++)
            push("perf_wrap", 1, 4'b1101, 0, 0, 0, mk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        while (sb.size() != 0) begin
            step(r);
            checks++;
            if (obs() !== r.exp) begin
                errors++;
                $display("FAIL perf/%s: got %b want %b", r.name, obs(), r.exp);
            end
        end
        checks++;
        if (cyc_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cyc_cnt_wrap: got %0d want 1", cyc_cnt);
        end
        checks++;
        if (ret_cnt !== 4'd5) begin
            errors++;
            $display("FAIL ret_cnt_idle: got %0d want 5", ret_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_reset_mid_access();
`ifdef CTRL_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
